// File: rtl/burst_trigger_pkg.sv
// Shared types and helpers for the burst trigger.
// State encoding is one-hot; bit indices are exported for case decoding.
package burst_trigger_pkg;

  typedef enum logic [3:0] {
    FILL    = 4'b0001,
    ARMED   = 4'b0010,
    HOLDOFF = 4'b0100,
    QUIET   = 4'b1000
  } state_e;

  localparam int FILL_B    = 0;
  localparam int ARMED_B   = 1;
  localparam int HOLDOFF_B = 2;
  localparam int QUIET_B   = 3;

  function automatic int sum_width(int sdw, int win);
    return sdw + $clog2(win);
  endfunction

endpackage

// File: rtl/burst_trigger_if.sv
// Sample stream bundle: valid plus signed sample.
// No ready line; the stream is never back-pressured.
interface burst_trigger_if #(
  parameter int SDW = 8
);
  logic           axiv;
  logic [SDW-1:0] axid;

  modport master (output axiv, output axid);
  modport slave  (input  axiv, input  axid);
endinterface

// File: rtl/burst_trigger_delay_line.sv
// Magnitude window history: shift register stepping on valid.
// oldest_o shows the entry about to be dropped this step.
module magnitude_delay_line
  import burst_trigger_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] oldest_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // shift in the newest magnitude on every valid sample
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign oldest_o = mem_q[DEPTH-1];

endmodule

// File: rtl/burst_trigger.sv
// Energy-detect burst trigger with 2-cycle aligned sample forward.
// Optional macro BURST_TRIGGER_STATS_EN adds trigger_count_o.
module burst_trigger
  import burst_trigger_pkg::*;
#(
  parameter  int SAMPLE_DATA_WIDTH = 8,
  parameter  int WINDOW_LENGTH     = 64,
  parameter  int HOLDOFF_SAMPLES   = 1000,
  localparam int SW = sum_width(SAMPLE_DATA_WIDTH, WINDOW_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_trigger_if.slave        s_if,
  burst_trigger_if.master       m_if,
  input  logic [SW-1:0]         threshold_high_i,
  input  logic [SW-1:0]         threshold_low_i,
  output logic                  trigger_o,
  output logic                  armed_o
`ifdef BURST_TRIGGER_STATS_EN
  ,
  output logic [15:0]           trigger_count_o
`endif
);

  localparam int SDW = SAMPLE_DATA_WIDTH;
  localparam int CNT_MAX =
    (WINDOW_LENGTH > HOLDOFF_SAMPLES) ?
    WINDOW_LENGTH : HOLDOFF_SAMPLES;
  localparam int CW = $clog2(CNT_MAX) + 1;

  logic           v1_q, v2_q;
  logic [SDW-1:0] d1_q, d2_q;
  logic [SDW-1:0] mag_d, mag1_q;
  logic [SDW-1:0] mag_old, mag_old_m;
  logic [SW-1:0]  sum_q, sum_d, sum_nx;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           trig_d, trig_q, hit;
  state_e         state_q, state_d;

  // |x|; the most negative value maps to 2^(SDW-1)
  assign mag_d = s_if.axid[SDW-1] ?
                 (~s_if.axid + SDW'(1)) : s_if.axid;

  // stage 1: capture sample and its magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      mag1_q <= '0;
    end else begin
      v1_q   <= s_if.axiv;
      d1_q   <= s_if.axid;
      mag1_q <= mag_d;
    end
  end

  magnitude_delay_line #(
    .DEPTH (WINDOW_LENGTH),
    .WIDTH (SDW)
  ) u_dl (
    .clk      (clk),
    .en_i     (v1_q),
    .din_i    (mag1_q),
    .oldest_o (mag_old)
  );

  // history is stale until the window has filled once
  assign mag_old_m = state_q[FILL_B] ? '0 : mag_old;
  assign sum_nx = sum_q + SW'(mag1_q) - SW'(mag_old_m);
  assign hit    = (sum_nx >= threshold_high_i);

  // next-state, counters and trigger decision per valid sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    trig_d  = 1'b0;
    if (v1_q) begin
      sum_d = sum_nx;
      unique case (1'b1)
        state_q[FILL_B]: begin
          if (cnt_q == CW'(WINDOW_LENGTH - 1)) begin
            cnt_d = '0;
            if (hit) begin
              trig_d  = 1'b1;
              state_d = HOLDOFF;
            end else begin
              state_d = ARMED;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        state_q[ARMED_B]: begin
          if (hit) begin
            trig_d  = 1'b1;
            cnt_d   = '0;
            state_d = HOLDOFF;
          end
        end
        state_q[HOLDOFF_B]: begin
          if (cnt_q == CW'(HOLDOFF_SAMPLES - 1)) begin
            cnt_d   = '0;
            state_d = QUIET;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        state_q[QUIET_B]: begin
          if (sum_nx < threshold_low_i) begin
            state_d = ARMED;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = FILL;
        end
      endcase
    end
  end

  // stage 2: state, window sum and aligned outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sum_q   <= '0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      v2_q    <= v1_q;
      d2_q    <= d1_q;
      trig_q  <= trig_d;
    end
  end

  assign m_if.axiv = v2_q;
  assign m_if.axid = d2_q;
  assign trigger_o = trig_q;
  assign armed_o   = state_q[ARMED_B];

`ifdef BURST_TRIGGER_STATS_EN
  logic [15:0] tcnt_q;

  // saturating count of emitted triggers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (trig_d && tcnt_q != 16'hFFFF) begin
      tcnt_q <= tcnt_q + 16'd1;
    end
  end

  assign trigger_count_o = tcnt_q;
`endif

endmodule

// File: tb/tb_burst_trigger.sv
// Self-checking bench for burst_trigger (SDW=8, window 4, holdoff 8).
// Vector table drives stimulus; a tagged scoreboard checks the outputs.
module tb_burst_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] thi = 10'd200;
  logic [9:0] tlo = 10'd100;
  logic       trig;
  logic       arm;
`ifdef BURST_TRIGGER_STATS_EN
  logic [15:0] tcnt;
`endif

  burst_trigger_if #(.SDW(8)) in_if ();
  burst_trigger_if #(.SDW(8)) out_if ();

  burst_trigger #(
    .SAMPLE_DATA_WIDTH (8),
    .WINDOW_LENGTH     (4),
    .HOLDOFF_SAMPLES   (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_if             (in_if),
    .m_if             (out_if),
    .threshold_high_i (thi),
    .threshold_low_i  (tlo),
    .trigger_o        (trig),
    .armed_o          (arm)
`ifdef BURST_TRIGGER_STATS_EN
    ,
    .trigger_count_o  (tcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       t;
    int         tag;
  } exp_t;

  typedef struct {
    int         op;
    bit         v;
    logic [7:0] d;
    bit         t;
    bit         arm;
    logic [9:0] thi;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   negcnt  = 0;
  int   exp_cnt = 0;
  bit   started = 0;
  logic [9:0] bthi = 10'd200;

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  function automatic void s(logic [7:0] d, bit t);
    tbl.push_back('{0, 1'b1, d, t, 1'b0, bthi});
  endfunction

  function automatic void g();
    tbl.push_back('{0, 1'b0, 8'h00, 1'b0, 1'b0, bthi});
  endfunction

  function automatic void r();
    tbl.push_back('{1, 1'b0, 8'h00, 1'b0, 1'b0, bthi});
  endfunction

  function automatic void a(bit e);
    tbl.push_back('{2, 1'b0, 8'h00, 1'b0, e, bthi});
  endfunction

  task automatic drive(bit v, logic [7:0] d, bit t,
                       logic [9:0] th);
    @(posedge clk);
    #1;
    in_if.axiv = v;
    in_if.axid = d;
    thi = th;
    if (v) begin
      sb.push_back('{d, t, negcnt + 3});
      if (t) exp_cnt++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    started = 1'b1;
    in_if.axiv = 1'b0;
    in_if.axid = 8'h00;
    #1;
    check("rst_axiov", {31'b0, out_if.axiv}, 0);
    check("rst_axiod", {24'b0, out_if.axid}, 0);
    check("rst_trigger", {31'b0, trig}, 0);
    check("rst_armed", {31'b0, arm}, 0);
`ifdef BURST_TRIGGER_STATS_EN
    check("rst_tcount", {16'b0, tcnt}, 0);
`endif
    sb.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain_check(bit e);
    repeat (3) drive(1'b0, 8'h00, 1'b0, thi);
    check("armed", {31'b0, arm}, {31'b0, e});
`ifdef BURST_TRIGGER_STATS_EN
    check("tcount", {16'b0, tcnt}, exp_cnt);
`endif
  endtask

  // output monitor: pop scoreboard on each forwarded sample
  always @(negedge clk) begin
    negcnt++;
    if (started && !rst) begin
      if (out_if.axiv) begin
        check("sb_nonempty", {31'b0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("axiod", {24'b0, out_if.axid}, {24'b0, e.d});
          check("trigger", {31'b0, trig}, {31'b0, e.t});
          check("latency", negcnt, e.tag);
        end
      end else begin
        check("trig_no_valid", {31'b0, trig}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_if.axiv = 1'b0;
    in_if.axid = 8'h00;

    // 1: +60 x4 triggers on the 4th (sum 240)
    r();
    repeat (3) s(8'd60, 0);
    s(8'd60, 1);
    a(0);
    // 2: FILL->ARMED sample is evaluated (sum 381)
    r();
    repeat (3) s(8'd127, 0);
    s(8'd0, 1);
    // 3: holdoff, quiet, re-arm, re-trigger
    repeat (8) s(8'd127, 0);
    repeat (4) s(8'd127, 0);
    repeat (4) s(8'd0, 0);
    a(1);
    s(8'd127, 0);
    s(8'd127, 1);
    a(0);
    // 4: most negative sample, magnitude 128
    r();
    repeat (3) s(8'h80, 0);
    s(8'h80, 1);
    a(0);
    // exact threshold boundary: 199 no, 200 yes
    r();
    repeat (3) s(8'd50, 0);
    s(8'd49, 0);
    a(1);
    s(8'd50, 0);
    s(8'd51, 1);
    a(0);
    // 5: valid gaps mirrored at the output
    r();
    for (int i = 0; i < 4; i++) begin
      s(8'd60, i == 3);
      if (i != 3) begin g(); g(); end
    end
    a(0);
    // threshold_high = 0 fires on first ARMED sample
    bthi = 10'd0;
    r();
    repeat (3) s(8'd0, 0);
    s(8'd0, 1);
    a(0);
    bthi = 10'd200;
    // 6: reset in HOLDOFF, window refills from empty
    r();
    repeat (3) s(8'd60, 0);
    s(8'd60, 1);
    repeat (3) s(8'd60, 0);
    r();
    repeat (3) s(8'd127, 0);
    a(0);
    s(8'd0, 1);
    a(0);

    foreach (tbl[i]) begin
      unique case (tbl[i].op)
        0: drive(tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].thi);
        1: do_reset();
        default: drain_check(tbl[i].arm);
      endcase
    end

    repeat (4) drive(1'b0, 8'h00, 1'b0, thi);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
